mipi_lane_sequencer: RTL and testbench

- Controller for the XO3L MIPI D-PHY transmit lanes.
- Sequences the lane control signals (`lp*_out`, `lp*_dir`, `hs_clk_en`, `hs_data_en`, `byte_D*`) through the power-up idle wait and each complete HS burst: LP-11 → LP-01 → LP-00 → HS-zero → sync → payload → trailer → LP-11.
- Replaces hand-driven, static control of the PHY wrapper.
- A payload source hands over bytes through a valid/ready interface.

---
 rtl/mipi_lane_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_mipi_lane_sequencer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mipi_lane_sequencer.sv
`default_nettype none
// mipi_lane_sequencer -- XO3L MIPI D-PHY TX lane sequencer: power-up LP-11 wait, then LP-01/LP-00/HS bursts.
// Optional macro LANE1_EN: lane 1 carries i_data1 and mirrors lane 0 LP levels. Revision 1.0.
module mipi_lane_sequencer #(
  parameter int T_INIT  = 1080000,
  parameter int T_LPX   = 5,
  parameter int T_PREP  = 4,
  parameter int T_ZERO  = 12,
  parameter int T_TRAIL = 6,
  parameter int T_EXIT  = 10
) (
  input  logic       i_clk,
  input  logic       reset_n,
  input  logic       i_start,
  input  logic       i_valid,
  input  logic [7:0] i_data0,
  input  logic [7:0] i_data1,
  input  logic       i_last,
  output logic       o_ready,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_underrun,
  output logic [7:0] byte_D0,
  output logic [7:0] byte_D1,
  output logic [1:0] lp0_out,
  output logic [1:0] lp1_out,
  output logic       lp0_dir,
  output logic       lp1_dir,
  output logic       hs_clk_en,
  output logic       hs_data_en
);

  typedef enum logic [3:0] {
    S_INIT  = 4'd0,
    S_IDLE  = 4'd1,
    S_LPX   = 4'd2,
    S_PREP  = 4'd3,
    S_ZERO  = 4'd4,
    S_SYNC  = 4'd5,
    S_DATA  = 4'd6,
    S_TRAIL = 4'd7,
    S_EXIT  = 4'd8
  } state_t;

  localparam logic [23:0] C_INIT  = 24'(T_INIT - 1);
  localparam logic [23:0] C_LPX   = 24'(T_LPX - 1);
  localparam logic [23:0] C_PREP  = 24'(T_PREP - 1);
  localparam logic [23:0] C_ZERO  = 24'(T_ZERO - 1);
  localparam logic [23:0] C_TRAIL = 24'(T_TRAIL - 1);
  localparam logic [23:0] C_EXIT  = 24'(T_EXIT - 1);
  localparam logic [7:0]  C_SYNC_BYTE = 8'hB8;

  state_t      state, state_nx;
  logic [23:0] cnt, cnt_nx;
  logic        take;
  logic        cnt_done;
  logic [1:0]  lp_nx;
  logic        ready_nx, underrun_nx, done_nx, busy_nx, hs_clk_nx, hs_data_nx;
  logic [7:0]  d0_nx;

  // Next HS byte for one lane. A DATA cycle without a transfer repeats the
  // current byte; the trailer inverts the last serialized bit (MSB).
  function automatic logic [7:0] lane_byte(input state_t cs, input state_t ns, input logic tk,
                                           input logic [7:0] cur, input logic [7:0] din);
    lane_byte = 8'h00;
    case (ns)
      S_ZERO:  lane_byte = 8'h00;
      S_SYNC:  lane_byte = C_SYNC_BYTE;
      S_DATA:  lane_byte = tk ? din : cur;
      S_TRAIL: lane_byte = (cs == S_DATA) ? {8{~cur[7]}} : cur;
      default: lane_byte = 8'h00;
    endcase
  endfunction

  assign take     = (state == S_DATA) && o_ready && i_valid;
  assign cnt_done = (cnt == 24'd0);

  always_comb begin
    state_nx = state;
    case (state)
      S_INIT:  if (cnt_done) state_nx = S_IDLE;
      S_IDLE:  if (i_start)  state_nx = S_LPX;
      S_LPX:   if (cnt_done) state_nx = S_PREP;
      S_PREP:  if (cnt_done) state_nx = S_ZERO;
      S_ZERO:  if (cnt_done) state_nx = S_SYNC;
      S_SYNC:  state_nx = S_DATA;
      // ready drops after the i_last transfer so the last byte gets its own
      // DATA cycle on the lanes before the trailer starts.
      S_DATA:  if (!o_ready) state_nx = S_TRAIL;
      S_TRAIL: if (cnt_done) state_nx = S_EXIT;
      S_EXIT:  if (cnt_done) state_nx = S_IDLE;
      default: state_nx = S_INIT;
    endcase
  end

  always_comb begin
    cnt_nx = cnt_done ? cnt : cnt - 24'd1;
    if (state_nx != state) begin
      case (state_nx)
        S_LPX:   cnt_nx = C_LPX;
        S_PREP:  cnt_nx = C_PREP;
        S_ZERO:  cnt_nx = C_ZERO;
        S_TRAIL: cnt_nx = C_TRAIL;
        S_EXIT:  cnt_nx = C_EXIT;
        default: cnt_nx = 24'd0;
      endcase
    end
  end

  always_comb begin
    lp_nx       = 2'b00;
    hs_clk_nx   = 1'b0;
    hs_data_nx  = 1'b0;
    busy_nx     = (state_nx != S_IDLE);
    done_nx     = (state == S_EXIT) && (state_nx == S_IDLE);
    ready_nx    = (state_nx == S_DATA) && !(take && i_last);
    underrun_nx = o_underrun;
    d0_nx       = lane_byte(state, state_nx, take, byte_D0, i_data0);
    case (state_nx)
      S_INIT, S_IDLE, S_EXIT: lp_nx = 2'b11;
      S_LPX:                  lp_nx = 2'b01;
      default:                lp_nx = 2'b00;
    endcase
    case (state_nx)
      S_LPX, S_PREP:                  hs_clk_nx = 1'b1;
      S_ZERO, S_SYNC, S_DATA, S_TRAIL: begin
        hs_clk_nx  = 1'b1;
        hs_data_nx = 1'b1;
      end
      default: ;
    endcase
    if ((state == S_IDLE) && (state_nx == S_LPX))
      underrun_nx = 1'b0;
    else if ((state == S_DATA) && o_ready && !i_valid)
      underrun_nx = 1'b1;
  end

  always_ff @(posedge i_clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_INIT;
      cnt        <= C_INIT;
      lp0_out    <= 2'b11;
      hs_clk_en  <= 1'b0;
      hs_data_en <= 1'b0;
      byte_D0    <= 8'h00;
      o_ready    <= 1'b0;
      o_done     <= 1'b0;
      o_underrun <= 1'b0;
      o_busy     <= 1'b1;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      lp0_out    <= lp_nx;
      hs_clk_en  <= hs_clk_nx;
      hs_data_en <= hs_data_nx;
      byte_D0    <= d0_nx;
      o_ready    <= ready_nx;
      o_done     <= done_nx;
      o_underrun <= underrun_nx;
      o_busy     <= busy_nx;
    end
  end

  assign lp0_dir = 1'b1;
  assign lp1_dir = 1'b1;

`ifdef LANE1_EN
  logic [7:0] d1_nx;

  always_comb d1_nx = lane_byte(state, state_nx, take, byte_D1, i_data1);

  always_ff @(posedge i_clk or negedge reset_n) begin
    if (!reset_n) begin
      lp1_out <= 2'b11;
      byte_D1 <= 8'h00;
    end else begin
      lp1_out <= lp_nx;
      byte_D1 <= d1_nx;
    end
  end
`else
  logic unused_data1;
  assign unused_data1 = ^i_data1;
  assign lp1_out      = 2'b11;
  assign byte_D1      = 8'h00;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mipi_lane_sequencer.sv
`default_nettype none
// tb_mipi_lane_sequencer -- directed self-checking bench; T_INIT=20, other timings at their defaults.
module tb_mipi_lane_sequencer;

  logic       i_clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       i_start = 1'b0;
  logic       i_valid = 1'b0;
  logic [7:0] i_data0 = 8'h00;
  logic [7:0] i_data1 = 8'h00;
  logic       i_last = 1'b0;
  logic       o_ready, o_busy, o_done, o_underrun;
  logic [7:0] byte_D0, byte_D1;
  logic [1:0] lp0_out, lp1_out;
  logic       lp0_dir, lp1_dir, hs_clk_en, hs_data_en;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 i_clk = ~i_clk;

  mipi_lane_sequencer #(
    .T_INIT (20),
    .T_LPX  (5),
    .T_PREP (4),
    .T_ZERO (12),
    .T_TRAIL(6),
    .T_EXIT (10)
  ) dut (
    .i_clk     (i_clk),
    .reset_n   (reset_n),
    .i_start   (i_start),
    .i_valid   (i_valid),
    .i_data0   (i_data0),
    .i_data1   (i_data1),
    .i_last    (i_last),
    .o_ready   (o_ready),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_underrun(o_underrun),
    .byte_D0   (byte_D0),
    .byte_D1   (byte_D1),
    .lp0_out   (lp0_out),
    .lp1_out   (lp1_out),
    .lp0_dir   (lp0_dir),
    .lp1_dir   (lp1_dir),
    .hs_clk_en (hs_clk_en),
    .hs_data_en(hs_data_en)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Called right after reset release: 20 INIT cycles, then the first IDLE cycle.
  task automatic init_wait();
    for (int i = 1; i <= 20; i++) begin
      check($sformatf("init_busy@%0d", i), o_busy, 1);
      check($sformatf("init_lp0@%0d", i), lp0_out, 2'b11);
      check($sformatf("init_hs@%0d", i), {hs_clk_en, hs_data_en}, 2'b00);
      tick();
    end
    check("idle_busy", o_busy, 0);
    check("idle_lp0", lp0_out, 2'b11);
  endtask

  // Entered on the first LPX cycle (t=0). Timeline: LPX 0-4, PREP 5-8, ZERO 9-20,
  // SYNC 21, DATA 22..25+g, TRAIL 26+g..31+g, EXIT 32+g..41+g, IDLE 42+g.
  // Bytes b0,b1 offered at t=22,23; g idle cycles; b2 with i_last at t=24+g.
  task automatic burst(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                       input logic [7:0] d1, input int g, input logic hold);
    logic [7:0] e0, e1;
    logic [1:0] elp;
    for (int t = 0; t <= 42 + g; t++) begin
      i_start = hold;
      i_valid = 1'b0;
      i_last  = 1'b0;
      i_data0 = 8'h00;
      i_data1 = d1;
      if (t == 22) begin
        i_valid = 1'b1; i_data0 = b0;
      end else if (t == 23) begin
        i_valid = 1'b1; i_data0 = b1;
      end else if (t == 24 + g) begin
        i_valid = 1'b1; i_data0 = b2; i_last = 1'b1;
      end

      if (t == 21 || t == 22)             e0 = 8'hB8;
      else if (t == 23)                   e0 = b0;
      else if (t >= 24 && t <= 24 + g)    e0 = b1;
      else if (t == 25 + g)               e0 = b2;
      else if (t >= 26 + g && t <= 31 + g) e0 = {8{~b2[7]}};
      else                                e0 = 8'h00;

      if (t <= 4)           elp = 2'b01;
      else if (t <= 31 + g) elp = 2'b00;
      else                  elp = 2'b11;

`ifdef LANE1_EN
      if (t == 21 || t == 22)              e1 = 8'hB8;
      else if (t >= 23 && t <= 25 + g)     e1 = d1;
      else if (t >= 26 + g && t <= 31 + g) e1 = {8{~d1[7]}};
      else                                 e1 = 8'h00;
      check($sformatf("lp1@%0d", t), lp1_out, elp);
`else
      e1 = 8'h00;
      check($sformatf("lp1@%0d", t), lp1_out, 2'b11);
`endif
      check($sformatf("d0@%0d", t), byte_D0, e0);
      check($sformatf("d1@%0d", t), byte_D1, e1);
      check($sformatf("lp0@%0d", t), lp0_out, elp);
      check($sformatf("hsclk@%0d", t), hs_clk_en, t <= 31 + g);
      check($sformatf("hsdat@%0d", t), hs_data_en, t >= 9 && t <= 31 + g);
      check($sformatf("ready@%0d", t), o_ready, t >= 22 && t <= 24 + g);
      check($sformatf("busy@%0d", t), o_busy, t <= 41 + g);
      check($sformatf("done@%0d", t), o_done, t == 42 + g);
      check($sformatf("unrun@%0d", t), o_underrun, g > 0 && t >= 25);
      check($sformatf("dir@%0d", t), {lp0_dir, lp1_dir}, 2'b11);
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    i_start = 1'b1;
    #12;
    check("rst_lp0", lp0_out, 2'b11);
    check("rst_lp1", lp1_out, 2'b11);
    check("rst_dir", {lp0_dir, lp1_dir}, 2'b11);
    check("rst_hs", {hs_clk_en, hs_data_en}, 2'b00);
    check("rst_d0", byte_D0, 8'h00);
    check("rst_d1", byte_D1, 8'h00);
    check("rst_flags", {o_ready, o_done, o_underrun}, 3'b000);
    check("rst_busy", o_busy, 1);
    @(negedge i_clk);
    reset_n = 1'b1;
    init_wait();
    tick();
    check("start_lp0", lp0_out, 2'b01);

    // start held for the whole burst: ignored mid-burst, restarts on first IDLE
    burst(8'h12, 8'h34, 8'hA5, 8'hC3, 0, 1'b1);
    burst(8'h12, 8'h34, 8'h7F, 8'hC3, 2, 1'b0);
    check("post_done", o_done, 0);
    check("post_busy", o_busy, 0);
    check("post_unrun", o_underrun, 1);
    i_start = 1'b1;
    tick();
    burst(8'h55, 8'hAA, 8'h80, 8'hC3, 0, 1'b0);

    // mid-burst reset during DATA
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    i_valid = 1'b1;
    i_data0 = 8'h11;
    repeat (23) tick();
    check("mid_ready", o_ready, 1);
    check("mid_hs", {hs_clk_en, hs_data_en}, 2'b11);
    #2;
    reset_n = 1'b0;
    #1;
    check("mrst_lp0", lp0_out, 2'b11);
    check("mrst_hs", {hs_clk_en, hs_data_en}, 2'b00);
    check("mrst_d0", byte_D0, 8'h00);
    check("mrst_ready", o_ready, 0);
    check("mrst_busy", o_busy, 1);
    i_valid = 1'b0;
    @(negedge i_clk);
    reset_n = 1'b1;
    init_wait();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
